// File: rtl/x2050_pkg.sv
// Shared definitions for the 2050 sign-statistics slice: SS codes, scanner
// states and decimal sign-nibble classifiers.
package x2050_pkg;

    localparam logic [5:0] SS_SGN_5     = 6'd5;
    localparam logic [5:0] SS_SGN_6     = 6'd6;
    localparam logic [5:0] SS_SGN_7     = 6'd7;
    localparam logic [5:0] SS_LSGN_SET  = 6'd32;
    localparam logic [5:0] SS_LSGN_CLR  = 6'd33;
    localparam logic [5:0] SS_RSGN_SET  = 6'd34;
    localparam logic [5:0] SS_RSGN_CLR  = 6'd35;
    localparam logic [5:0] SS_LSGN_L0   = 6'd36;
    localparam logic [5:0] SS_RSGN_R0   = 6'd37;
    localparam logic [5:0] SS_RSGN_SCAN = 6'd38;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    function automatic logic sign_negative(input logic [3:0] nib);
        return (nib == 4'hB) || (nib == 4'hD);
    endfunction

    function automatic logic sign_positive(input logic [3:0] nib);
        return (nib == 4'hA) || (nib == 4'hC) || (nib == 4'hE) || (nib == 4'hF);
    endfunction

    function automatic logic sign_invalid(input logic [3:0] nib);
        return (nib < 4'hA);
    endfunction

endpackage

// File: rtl/x2050_dec_scan.sv
// Multi-cycle packed-decimal field scanner, MSB nibble first.
// Present only when X2050_DECIMAL_SCAN_EN is defined; otherwise outputs are 0.
module x2050_dec_scan
    import x2050_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DIG_PER_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_has_sign,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_zero,
    output logic              o_negative,
    output logic              o_invalid
);

`ifdef X2050_DECIMAL_SCAN_EN
    localparam int GRP_W = 4 * DIG_PER_CYC;
    localparam int N_GRP = DATA_W / GRP_W;
    localparam int CNT_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;

    scan_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              has_sign_q, zero_acc_q, inv_acc_q;
    logic              zero_q, neg_q, inv_q, done_q;
    logic              last_grp_s, grp_nonzero_s, grp_inv_s, grp_neg_s;
    logic [3:0]        nib_s;

    assign last_grp_s = (cnt_q == CNT_W'(N_GRP - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a start while scanning is simply not looked at
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start)    state_d = ST_SCAN; else state_d = ST_IDLE;
            ST_SCAN: if (last_grp_s) state_d = ST_IDLE; else state_d = ST_SCAN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_busy = (state_q == ST_SCAN);
    end

    // Classify the current group; the sign is the last nibble of the last group
    always_comb begin
        grp_nonzero_s = 1'b0;
        grp_inv_s     = 1'b0;
        grp_neg_s     = 1'b0;
        nib_s         = 4'd0;
        for (int j = 0; j < DIG_PER_CYC; j++) begin
            nib_s = data_q[DATA_W-1-4*j -: 4];
            if (last_grp_s && has_sign_q && (j == DIG_PER_CYC - 1)) begin
                grp_neg_s = sign_negative(nib_s);
                grp_inv_s = grp_inv_s | sign_invalid(nib_s);
            end else begin
                grp_inv_s     = grp_inv_s | (nib_s > 4'd9);
                grp_nonzero_s = grp_nonzero_s | (nib_s != 4'd0);
            end
        end
    end

    // Operand shifter, accumulators and result registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_q     <= {DATA_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            has_sign_q <= 1'b0;
            zero_acc_q <= 1'b0;
            inv_acc_q  <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            inv_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (i_start) begin
                    data_q     <= i_data;
                    has_sign_q <= i_has_sign;
                    cnt_q      <= {CNT_W{1'b0}};
                    zero_acc_q <= 1'b1;
                    inv_acc_q  <= 1'b0;
                end
            end else begin
                data_q     <= data_q << GRP_W;
                zero_acc_q <= zero_acc_q & ~grp_nonzero_s;
                inv_acc_q  <= inv_acc_q | grp_inv_s;
                if (last_grp_s) begin
                    cnt_q  <= {CNT_W{1'b0}};
                    zero_q <= zero_acc_q & ~grp_nonzero_s;
                    neg_q  <= grp_neg_s;
                    inv_q  <= inv_acc_q | grp_inv_s;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign o_done     = done_q;
    assign o_zero     = zero_q;
    assign o_negative = neg_q;
    assign o_invalid  = inv_q;
`else
    logic unused_scan_s;
    assign unused_scan_s = ^{i_clk, i_reset, i_start, i_data, i_has_sign};
    assign o_busy     = 1'b0;
    assign o_done     = 1'b0;
    assign o_zero     = 1'b0;
    assign o_negative = 1'b0;
    assign o_invalid  = 1'b0;
`endif

endmodule

// File: rtl/x2050_sign_scan.sv
// 2050 R/L sign statistics driven by the SS micro-order field, plus the
// decimal field scanner (enabled by X2050_DECIMAL_SCAN_EN).
module x2050_sign_scan
    import x2050_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DIG_PER_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ros_advance,
    input  logic [5:0]        i_ss,
    input  logic [DATA_W-1:0] i_r_reg,
    input  logic [DATA_W-1:0] i_l_reg,
    input  logic [7:0]        i_w_reg,
    input  logic [7:0]        i_u,
    input  logic              i_scan_start,
    input  logic [DATA_W-1:0] i_scan_data,
    input  logic              i_scan_has_sign,
    output logic              o_r_sign_stat,
    output logic              o_l_sign_stat,
    output logic              o_invalid_decimal_ss,
    output logic              o_scan_busy,
    output logic              o_scan_done,
    output logic              o_scan_zero,
    output logic              o_scan_negative,
    output logic              o_scan_invalid
);

    logic r_sign_q, r_sign_d, l_sign_q, l_sign_d;
    logic u_neg_s, u_inv_s, w_pos_s, ss_sgn56_s;
    logic unused_bits_s;

    assign u_neg_s       = sign_negative(i_u[3:0]);
    assign u_inv_s       = sign_invalid(i_u[3:0]);
    assign w_pos_s       = sign_positive(i_w_reg[3:0]);
    assign ss_sgn56_s    = (i_ss == SS_SGN_5) || (i_ss == SS_SGN_6);
    assign unused_bits_s = ^{i_r_reg[DATA_W-2:0], i_l_reg[DATA_W-2:0], i_w_reg[7:4], i_u[7:4]};

    x2050_dec_scan #(
        .DATA_W      (DATA_W),
        .DIG_PER_CYC (DIG_PER_CYC)
    ) u_scan (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_scan_start),
        .i_data     (i_scan_data),
        .i_has_sign (i_scan_has_sign),
        .o_busy     (o_scan_busy),
        .o_done     (o_scan_done),
        .o_zero     (o_scan_zero),
        .o_negative (o_scan_negative),
        .o_invalid  (o_scan_invalid)
    );

    // SS decode into next sign-stat values; stats move only on a ROS advance
    always_comb begin
        r_sign_d = r_sign_q;
        l_sign_d = l_sign_q;
        if (i_ros_advance) begin
            case (i_ss)
                SS_SGN_5:    begin r_sign_d = u_neg_s & ~r_sign_q; l_sign_d = u_neg_s; end
                SS_SGN_6:    r_sign_d = u_neg_s & ~r_sign_q;
                SS_SGN_7:    begin r_sign_d = ~u_inv_s; l_sign_d = l_sign_q & ~w_pos_s; end
                SS_LSGN_SET: l_sign_d = 1'b1;
                SS_LSGN_CLR: l_sign_d = 1'b0;
                SS_RSGN_SET: r_sign_d = 1'b1;
                SS_RSGN_CLR: r_sign_d = 1'b0;
                SS_LSGN_L0:  l_sign_d = i_l_reg[DATA_W-1];
                SS_RSGN_R0:  r_sign_d = i_r_reg[DATA_W-1];
`ifdef X2050_DECIMAL_SCAN_EN
                SS_RSGN_SCAN: if (!o_scan_busy) r_sign_d = o_scan_negative; else r_sign_d = r_sign_q;
`endif
                default:     begin r_sign_d = r_sign_q; l_sign_d = l_sign_q; end
            endcase
        end else begin
            r_sign_d = r_sign_q;
            l_sign_d = l_sign_q;
        end
    end

    // Sign-stat registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sign_q <= 1'b0;
            l_sign_q <= 1'b0;
        end else begin
            r_sign_q <= r_sign_d;
            l_sign_q <= l_sign_d;
        end
    end

    assign o_r_sign_stat = r_sign_q;
    assign o_l_sign_stat = l_sign_q;

`ifdef X2050_DECIMAL_SCAN_EN
    assign o_invalid_decimal_ss = (ss_sgn56_s & u_inv_s) |
                                  ((i_ss == SS_RSGN_SCAN) & ~o_scan_busy & o_scan_invalid);
`else
    assign o_invalid_decimal_ss = ss_sgn56_s & u_inv_s;
`endif

endmodule

// File: tb/tb_x2050_sign_scan.sv
// Directed bench for x2050_sign_scan: sign-stat SS decode and, when
// X2050_DECIMAL_SCAN_EN is defined, the decimal scanner at 1 and 4 nibbles/cycle.
module tb_x2050_sign_scan;

    logic        clk = 1'b0;
    logic        rst, ros, start, shs;
    logic [5:0]  ss;
    logic [31:0] r_reg, l_reg, sdata;
    logic [7:0]  w_reg, u;
    logic a_r, a_l, a_inv, a_busy, a_done, a_zero, a_neg, a_sinv;
    logic b_r, b_l, b_inv, b_busy, b_done, b_zero, b_neg, b_sinv;
    int   checks = 0;
    int   errors = 0;

    logic [5:0] tbl_ss [0:9] = '{6'd34, 6'd32, 6'd35, 6'd33, 6'd36, 6'd34, 6'd37, 6'd39, 6'd0, 6'd33};
    logic [1:0] tbl_rl [0:9] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00};

    always #5 clk = ~clk;

    x2050_sign_scan #(.DATA_W(32), .DIG_PER_CYC(1)) dut (
        .i_clk(clk), .i_reset(rst), .i_ros_advance(ros), .i_ss(ss),
        .i_r_reg(r_reg), .i_l_reg(l_reg), .i_w_reg(w_reg), .i_u(u),
        .i_scan_start(start), .i_scan_data(sdata), .i_scan_has_sign(shs),
        .o_r_sign_stat(a_r), .o_l_sign_stat(a_l), .o_invalid_decimal_ss(a_inv),
        .o_scan_busy(a_busy), .o_scan_done(a_done), .o_scan_zero(a_zero),
        .o_scan_negative(a_neg), .o_scan_invalid(a_sinv));

    x2050_sign_scan #(.DATA_W(32), .DIG_PER_CYC(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_ros_advance(ros), .i_ss(ss),
        .i_r_reg(r_reg), .i_l_reg(l_reg), .i_w_reg(w_reg), .i_u(u),
        .i_scan_start(start), .i_scan_data(sdata), .i_scan_has_sign(shs),
        .o_r_sign_stat(b_r), .o_l_sign_stat(b_l), .o_invalid_decimal_ss(b_inv),
        .o_scan_busy(b_busy), .o_scan_done(b_done), .o_scan_zero(b_zero),
        .o_scan_negative(b_neg), .o_scan_invalid(b_sinv));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ros = 1'b0; ss = 6'd0; r_reg = 32'd0; l_reg = 32'd0;
        w_reg = 8'd0; u = 8'd0; start = 1'b0; sdata = 32'd0; shs = 1'b0;
        tick; tick;
        checks++;
        if ({a_r, a_l, a_inv, a_busy, a_done, a_zero, a_neg, a_sinv} !== 8'd0) begin
            errors++; $display("FAIL reset_a: got %b exp %b", {a_r, a_l, a_inv, a_busy, a_done, a_zero, a_neg, a_sinv}, 8'd0);
        end
        checks++;
        if ({b_r, b_l, b_inv, b_busy, b_done, b_zero, b_neg, b_sinv} !== 8'd0) begin
            errors++; $display("FAIL reset_b: got %b exp %b", {b_r, b_l, b_inv, b_busy, b_done, b_zero, b_neg, b_sinv}, 8'd0);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_ss56;
        ss = 6'd5; u = 8'h0B; ros = 1'b1; #1;
        checks++;
        if (a_inv !== 1'b0) begin errors++; $display("FAIL ss5_inv_b: got %b exp 0", a_inv); end
        tick;
        checks++;
        if ({a_r, a_l, b_r, b_l} !== 4'b1111) begin errors++; $display("FAIL ss5_first: got RL %b exp 1111", {a_r, a_l, b_r, b_l}); end
        tick;
        checks++;
        if ({a_r, a_l} !== 2'b01) begin errors++; $display("FAIL ss5_repeat: got RL %b exp 01", {a_r, a_l}); end
        u = 8'h03; #1;
        checks++;
        if (a_inv !== 1'b1) begin errors++; $display("FAIL ss5_inv_3: got %b exp 1", a_inv); end
        tick;
        checks++;
        if ({a_r, a_l} !== 2'b00) begin errors++; $display("FAIL ss5_u3: got RL %b exp 00", {a_r, a_l}); end
        ss = 6'd6; u = 8'h0D; #1;
        checks++;
        if (a_inv !== 1'b0) begin errors++; $display("FAIL ss6_inv_d: got %b exp 0", a_inv); end
        tick;
        checks++;
        if ({a_r, a_l} !== 2'b10) begin errors++; $display("FAIL ss6_d: got RL %b exp 10", {a_r, a_l}); end
        u = 8'h15; ros = 1'b0; #1;
        checks++;
        if (a_inv !== 1'b1) begin errors++; $display("FAIL ss6_inv_noadv: got %b exp 1", a_inv); end
        tick;
        checks++;
        if ({a_r, a_l} !== 2'b10) begin errors++; $display("FAIL ss6_hold: got RL %b exp 10", {a_r, a_l}); end
    endtask

    task automatic test_ss7;
        ros = 1'b1; ss = 6'd32; tick;
        ss = 6'd35; tick;
        checks++;
        if ({a_r, a_l} !== 2'b01) begin errors++; $display("FAIL ss7_setup: got RL %b exp 01", {a_r, a_l}); end
        ss = 6'd7; w_reg = 8'h0B; u = 8'h0C; #1;
        checks++;
        if (a_inv !== 1'b0) begin errors++; $display("FAIL ss7_inv: got %b exp 0", a_inv); end
        tick;
        checks++;
        if ({a_r, a_l} !== 2'b11) begin errors++; $display("FAIL ss7_wb_uc: got RL %b exp 11", {a_r, a_l}); end
        w_reg = 8'h0C; u = 8'h03; ros = 1'b0; tick;
        checks++;
        if ({a_r, a_l} !== 2'b11) begin errors++; $display("FAIL ss7_noadv: got RL %b exp 11", {a_r, a_l}); end
        ros = 1'b1; tick;
        checks++;
        if ({a_r, a_l} !== 2'b00) begin errors++; $display("FAIL ss7_wc_u3: got RL %b exp 00", {a_r, a_l}); end
    endtask

    task automatic test_set_clr;
        r_reg = 32'h7FFF_FFFF; l_reg = 32'h8000_0000; ros = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ss = tbl_ss[i];
            tick;
            checks++;
            if ({a_r, a_l} !== tbl_rl[i]) begin
                errors++; $display("FAIL set_clr[%0d] ss=%0d: got RL %b exp %b", i, tbl_ss[i], {a_r, a_l}, tbl_rl[i]);
            end
        end
        ros = 1'b0; ss = 6'd0;
    endtask

`ifdef X2050_DECIMAL_SCAN_EN
    // held = {zero, negative, invalid} that must persist until the new done
    task automatic run_scan(input logic [31:0] data, input logic hs, input logic [2:0] held, input logic inj);
        int n;
        n = 0;
        start = 1'b1; sdata = data; shs = hs;
        tick;
        start = inj;
        if (inj) begin sdata = 32'hFFFF_FFFF; shs = 1'b0; end
        checks++;
        if ({a_busy, a_done, b_busy, b_done} !== 4'b1010) begin
            errors++; $display("FAIL scan_e0: got busy/done %b exp 1010", {a_busy, a_done, b_busy, b_done});
        end
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                checks++;
                if ({b_busy, b_done} !== 2'b01) begin errors++; $display("FAIL dpc4_done_e2: got busy,done %b exp 01", {b_busy, b_done}); end
            end
            if (a_done) begin n = k; break; end
            checks++;
            if ({a_busy, a_zero, a_neg, a_sinv} !== {1'b1, held}) begin
                errors++; $display("FAIL scan_hold e%0d: got %b exp %b", k, {a_busy, a_zero, a_neg, a_sinv}, {1'b1, held});
            end
        end
        checks++;
        if (n != 8 || a_busy !== 1'b0) begin errors++; $display("FAIL scan_latency: got done at E%0d busy %b exp E8 busy 0", n, a_busy); end
    endtask

    task automatic test_scan_basic;
        run_scan(32'h0012_345C, 1'b1, 3'b000, 1'b1);
        checks++;
        if ({a_zero, a_neg, a_sinv, b_zero, b_neg, b_sinv} !== 6'b000000) begin
            errors++; $display("FAIL scan_basic: got %b exp 000000", {a_zero, a_neg, a_sinv, b_zero, b_neg, b_sinv});
        end
        tick;
        checks++;
        if (a_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b exp 0", a_done); end
    endtask

    task automatic test_scan_sign;
        run_scan(32'h0000_000D, 1'b1, 3'b000, 1'b0);
        checks++;
        if ({a_zero, a_neg, a_sinv, b_zero, b_neg, b_sinv} !== 6'b110110) begin
            errors++; $display("FAIL scan_neg_zero: got %b exp 110110", {a_zero, a_neg, a_sinv, b_zero, b_neg, b_sinv});
        end
        ss = 6'd38; ros = 1'b0; #1;
        checks++;
        if (a_inv !== 1'b0) begin errors++; $display("FAIL ss38_inv_valid: got %b exp 0", a_inv); end
        ros = 1'b1; tick;
        checks++;
        if ({a_r, b_r} !== 2'b11) begin errors++; $display("FAIL ss38_load: got R %b exp 11", {a_r, b_r}); end
        ss = 6'd0; ros = 1'b0;
    endtask

    task automatic test_scan_invalid;
        int n;
        n = 0;
        ss = 6'd35; ros = 1'b1; tick;
        ss = 6'd0; ros = 1'b0;
        start = 1'b1; sdata = 32'h00A1_234C; shs = 1'b1;
        tick;
        start = 1'b0; ss = 6'd38; ros = 1'b1; #1;
        checks++;
        if (a_inv !== 1'b0) begin errors++; $display("FAIL ss38_inv_busy: got %b exp 0", a_inv); end
        tick;
        checks++;
        if ({a_r, a_busy, a_zero, a_neg} !== 4'b0111) begin
            errors++; $display("FAIL ss38_busy_hold: got R,busy,z,n %b exp 0111", {a_r, a_busy, a_zero, a_neg});
        end
        ss = 6'd0; ros = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            tick;
            if (a_done) begin n = k; break; end
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL inv_latency: got E%0d exp E8", n); end
        checks++;
        if ({a_zero, a_neg, a_sinv, b_zero, b_neg, b_sinv} !== 6'b001001) begin
            errors++; $display("FAIL scan_invalid: got %b exp 001001", {a_zero, a_neg, a_sinv, b_zero, b_neg, b_sinv});
        end
        ss = 6'd38; ros = 1'b0; #1;
        checks++;
        if ({a_inv, b_inv} !== 2'b11) begin errors++; $display("FAIL ss38_inv_idle: got %b exp 11", {a_inv, b_inv}); end
        tick;
        checks++;
        if (a_r !== 1'b0) begin errors++; $display("FAIL ss38_noadv: got R %b exp 0", a_r); end
        ss = 6'd34; ros = 1'b1; tick;
        ss = 6'd38; tick;
        checks++;
        if (a_r !== 1'b0) begin errors++; $display("FAIL ss38_load_pos: got R %b exp 0", a_r); end
        ss = 6'd0; ros = 1'b0;
    endtask

    task automatic test_back_to_back;
        run_scan(32'h0000_0000, 1'b0, 3'b001, 1'b0);
        checks++;
        if ({a_zero, a_neg, a_sinv} !== 3'b100) begin errors++; $display("FAIL b2b_zero: got %b exp 100", {a_zero, a_neg, a_sinv}); end
        run_scan(32'h1234_5670, 1'b0, 3'b100, 1'b0);
        checks++;
        if ({a_zero, a_neg, a_sinv} !== 3'b000) begin errors++; $display("FAIL b2b_digits: got %b exp 000", {a_zero, a_neg, a_sinv}); end
        run_scan(32'h0000_000D, 1'b0, 3'b000, 1'b0);
        checks++;
        if ({a_zero, a_neg, a_sinv, b_zero, b_neg, b_sinv} !== 6'b001001) begin
            errors++; $display("FAIL b2b_nosign_d: got %b exp 001001", {a_zero, a_neg, a_sinv, b_zero, b_neg, b_sinv});
        end
    endtask

    task automatic test_reset_mid_scan;
        logic seen;
        seen = 1'b0;
        run_scan(32'h0000_000D, 1'b1, 3'b001, 1'b0);
        ros = 1'b1; ss = 6'd34; tick;
        ss = 6'd32; tick;
        ros = 1'b0; ss = 6'd0;
        start = 1'b1; sdata = 32'h0012_345C; shs = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({a_r, a_l, a_busy, a_done, a_zero, a_neg, a_sinv} !== 7'd0) begin
            errors++; $display("FAIL reset_mid_a: got %b exp 0000000", {a_r, a_l, a_busy, a_done, a_zero, a_neg, a_sinv});
        end
        checks++;
        if ({b_r, b_l, b_busy, b_done, b_zero, b_neg, b_sinv} !== 7'd0) begin
            errors++; $display("FAIL reset_mid_b: got %b exp 0000000", {b_r, b_l, b_busy, b_done, b_zero, b_neg, b_sinv});
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick;
            seen = seen | a_done | a_busy;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_done: got activity %b exp 0", seen); end
    endtask
`else
    task automatic test_scan_disabled;
        logic seen;
        seen = 1'b0;
        ros = 1'b1; ss = 6'd34; tick;
        ros = 1'b0; ss = 6'd0;
        start = 1'b1; sdata = 32'h00A1_234D; shs = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick;
            seen = seen | a_busy | a_done | a_zero | a_neg | a_sinv | b_busy | b_done;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL scan_tied_off: got activity %b exp 0", seen); end
        ss = 6'd38; ros = 1'b1; u = 8'h03; #1;
        checks++;
        if (a_inv !== 1'b0) begin errors++; $display("FAIL ss38_inv_off: got %b exp 0", a_inv); end
        tick;
        checks++;
        if (a_r !== 1'b1) begin errors++; $display("FAIL ss38_noop: got R %b exp 1", a_r); end
        ss = 6'd0; ros = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_ss56;
        test_ss7;
        test_set_clr;
`ifdef X2050_DECIMAL_SCAN_EN
        test_scan_basic;
        test_scan_sign;
        test_scan_invalid;
        test_back_to_back;
        test_reset_mid_scan;
`else
        test_scan_disabled;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/x2050_sign_scan.md
# x2050_sign_scan

Parametrised sign-statistics unit for the 2050 CPU data path, driven by the micro-order SS field on each ROS advance. It maintains the R and L sign stats and flags invalid decimal signs. It adds a multi-cycle packed-decimal field scanner that validates digits, detects zero, classifies the sign nibble, and can load its sign result into the R sign stat through a new SS code.

## Interface
Parameters:
- DATA_W, 32: width of R/L registers and scan operand; multiple of 4.
- DIG_PER_CYC, 1: nibbles examined per scan cycle; 1, 2 or 4; (DATA_W/4) divisible by it.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_ros_advance  in  1  micro-order completes this cycle; sign stats update only when high.
- i_ss  in  6  SS field of the current micro-order.
- i_r_reg, i_l_reg  in  DATA_W  R and L registers; MSB is IBM bit 0.
- i_w_reg, i_u  in  8  W register and U bus; only [3:0] used.
- i_scan_start  in  1  request a scan of i_scan_data.
- i_scan_data  in  DATA_W  packed-decimal operand, sampled on accepted start.
- i_scan_has_sign  in  1  nibble [3:0] is a sign, not a digit; sampled with start.
- o_r_sign_stat, o_l_sign_stat  out  1  sign stats (registered).
- o_invalid_decimal_ss  out  1  combinational invalid-sign indication.
- o_scan_busy  out  1  scan in progress.
- o_scan_done  out  1  one-cycle pulse, results valid.
- o_scan_zero, o_scan_negative, o_scan_invalid  out  1  scan results, held until next accepted start.

## Operation
- Sign classes on nibble x: negative = B,D; positive = A,C,E,F; invalid = x < A.
- SS decode (applied on rising edge when i_ros_advance=1; other codes leave stats unchanged):
  - 5: R <= U-negative & ~R; L <= U-negative.
  - 6: R <= U-negative & ~R.
  - 7: R <= ~U-invalid; L <= L & ~W-positive.
  - 32/33: L <= 1/0. 34/35: R <= 1/0.
  - 36: L <= i_l_reg[DATA_W-1]. 37: R <= i_r_reg[DATA_W-1].
  - 38: R <= o_scan_negative, only when o_scan_busy=0; while busy, R holds.
- o_invalid_decimal_ss = (ss 5 or 6) & U-invalid, OR ss 38 & ~busy & o_scan_invalid. Not gated by i_ros_advance.
- Scanner FSM states: IDLE, SCAN.
  - IDLE: i_scan_start=1 captures data and has_sign, clears counter and accumulators, goes to SCAN.
  - SCAN: each cycle examines the next DIG_PER_CYC nibbles, starting at the most significant. A digit nibble > 9 sets invalid. A nonzero digit clears zero.
  - The sign nibble (when has_sign) is excluded from the digit and zero checks. negative = sign in {B,D}; sign < A sets invalid. Without has_sign, negative = 0 and nibble 0 is treated as a digit.
  - After the last group, go to IDLE and pulse o_scan_done.
- i_scan_start while busy is ignored. The scanner runs regardless of i_ros_advance.

## Timing
- Reset: both sign stats, busy, done, zero, negative and invalid are 0; FSM returns to IDLE; counter is 0. Reset mid-scan aborts the scan with no done pulse.
- Scan cycles N = DATA_W / (4·DIG_PER_CYC).
- Start sampled at edge E0. busy=1 from E0 through E_N. At E_N: busy=0, done=1 for exactly one cycle, results valid.
- Results are written only at E_N and never change while busy.
- Start asserted in the cycle where done=1 is accepted (FSM is IDLE); results stay valid until that start's E_N.
- Sign-stat update takes effect at the edge where i_ros_advance=1. When i_ros_advance=0, stats hold regardless of SS.

## Configuration
- X2050_DECIMAL_SCAN_EN defined: scanner, SS 38 and its invalid term are present.
- Not defined: scanner logic omitted. o_scan_* tied to 0, SS 38 is a no-op, and o_invalid_decimal_ss covers SS 5/6 only. Sign-stat behaviour is otherwise identical.

## Structure
- Shared package x2050_pkg holds:
  - SS code constants: SS_SGN_5/6/7, SS_LSGN_SET/CLR (32/33), SS_RSGN_SET/CLR (34/35), SS_LSGN_L0 (36), SS_RSGN_R0 (37), SS_RSGN_SCAN (38).
  - Scanner state enum.
  - Functions sign_negative/positive/invalid(nibble).
- Sub-module x2050_dec_scan implements the scanner FSM. The top level keeps the sign-stat registers and SS decode.

## Test plan
- DATA_W=32, DIG_PER_CYC=1, start with 32'h0012345C, has_sign=1 -> busy for 8 cycles, done at E8; zero=0, negative=0, invalid=0.
- Start with 32'h0000000D, has_sign=1; then ss=38 with ros_advance=1 after done -> zero=1, negative=1; R sign becomes 1.
- Start with 32'h00A1234C -> invalid=1. Hold ss=38 while idle -> o_invalid_decimal_ss=1.
- ss=5, U=8'h0B, R=0, ros_advance=1 -> R=1, L=1. Repeat -> R=0, L=1. ss=5, U=8'h03 -> o_invalid_decimal_ss=1.
- ss=7, L=1, W=8'h0B, U=8'h0C -> L=1, R=1. Same with ros_advance=0 -> no change.
- Assert reset at E3 of a scan -> busy=0, no done pulse, all outputs 0. DIG_PER_CYC=4 run -> done at E2.
